// File: rtl/pixel_group_scheduler.sv
// Pixel group scheduler.
// Collects pixel event strobes into a pending map, grants pixel groups in
// round-robin order and serves up to MAX_BURST pixels per group tenure.
// set_i and gnt_o are flattened row-major: bit index = row*ARRAY_COLS + col.
// Handshake: valid_o is high for the whole GRANT state and the address
// (gnt_o, x_add_o, y_add_o) is held stable until ack_i is seen high on a
// rising edge while valid_o is high. That edge is the transfer. ack_i is
// ignored while valid_o is low.
module pixel_group_scheduler #(
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4,
  parameter int GRP_ROWS   = 2,
  parameter int GRP_COLS   = 2,
  parameter int MAX_BURST  = 4,
  localparam int NG_R    = ARRAY_ROWS / GRP_ROWS,
  localparam int NG_C    = ARRAY_COLS / GRP_COLS,
  localparam int NUM_GRP = NG_R * NG_C,
  localparam int NUM_PIX = ARRAY_ROWS * ARRAY_COLS,
  localparam int AW_X    = (ARRAY_COLS > 1) ? $clog2(ARRAY_COLS) : 1,
  localparam int AW_Y    = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_PIX-1:0] set_i,
  input  logic               enable_i,
  input  logic               ack_i,
  output logic               valid_o,
  output logic [NUM_PIX-1:0] gnt_o,
  output logic [AW_X-1:0]    x_add_o,
  output logic [AW_Y-1:0]    y_add_o,
  output logic [NUM_GRP-1:0] grp_req_o,
  output logic               grp_release_o,
  output logic               active_o,
  output logic [1:0]         state_o
);

  localparam int GW = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  // Reject configurations where groups do not tile the array.
  if ((ARRAY_ROWS % GRP_ROWS) != 0 || (ARRAY_COLS % GRP_COLS) != 0 || MAX_BURST < 1) begin : g_bad_cfg
    $error("pixel_group_scheduler: groups must tile the array and MAX_BURST must be >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, GRANT = 2'd2, RELEASE = 2'd3} state_t;

  state_t             state;
  logic [NUM_PIX-1:0] pend;
  logic [NUM_PIX-1:0] pend_nxt;
  logic [NUM_PIX-1:0] pix_oh;
  logic [NUM_PIX-1:0] clr;
  logic [NUM_GRP-1:0] grp_req;
  logic [GW-1:0]      grp_r;
  logic [GW-1:0]      last_grp;
  logic [GW-1:0]      next_grp;
  logic [PW-1:0]      pix_r;
  logic [PW-1:0]      first_pix;
  logic [BW-1:0]      burst_cnt;
  logic               grp_left;
  logic               burst_last;

  // Group number that owns flattened pixel index i.
  function automatic int grp_of(input int i);
    return ((i / ARRAY_COLS) / GRP_ROWS) * NG_C + (i % ARRAY_COLS) / GRP_COLS;
  endfunction

  // Pending map update: an ack clears the served pixel, a same-edge set wins.
  always_comb begin
    pix_oh   = NUM_PIX'(1) << pix_r;
    clr      = (state == GRANT && ack_i) ? pix_oh : '0;
    pend_nxt = (pend & ~clr) | set_i;
  end

  // Per-group request is the OR of the pending bits inside the group.
  always_comb begin
    grp_req = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      if (pend[i]) grp_req[grp_of(i)] = 1'b1;
    end
  end

  // Round-robin pick: first requesting group after last_grp, with wrap.
  always_comb begin
    next_grp = '0;
    for (int k = NUM_GRP; k >= 1; k--) begin
      if (grp_req[(int'(last_grp) + k) % NUM_GRP]) next_grp = GW'((int'(last_grp) + k) % NUM_GRP);
    end
  end

  // Lowest row-major pending pixel inside the tenured group.
  always_comb begin
    first_pix = '0;
    for (int i = NUM_PIX - 1; i >= 0; i--) begin
      if (pend[i] && grp_of(i) == int'(grp_r)) first_pix = PW'(i);
    end
  end

  // Tenure end conditions evaluated on the acked edge (after clear and new sets).
  always_comb begin
    grp_left = 1'b0;
    for (int i = 0; i < NUM_PIX; i++) begin
      if (pend_nxt[i] && grp_of(i) == int'(grp_r)) grp_left = 1'b1;
    end
    burst_last = (int'(burst_cnt) + 1 == MAX_BURST);
  end

  // Pending register, cleared by reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) pend <= '0;
    else          pend <= pend_nxt;
  end

  // Scheduler FSM: group pick, pixel pick, handshake, release.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      grp_r     <= '0;
      pix_r     <= '0;
      burst_cnt <= '0;
      last_grp  <= GW'(NUM_GRP - 1);
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && (|grp_req)) begin
            grp_r <= next_grp;
            state <= SELECT;
          end
        end
        SELECT: begin
          pix_r <= first_pix;
          state <= GRANT;
        end
        GRANT: begin
          if (ack_i) begin
            burst_cnt <= burst_cnt + BW'(1);
            state     <= (burst_last || !grp_left) ? RELEASE : SELECT;
          end
        end
        RELEASE: begin
          last_grp  <= grp_r;
          burst_cnt <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; address fields are zero outside GRANT.
  always_comb begin
    valid_o       = (state == GRANT);
    gnt_o         = valid_o ? pix_oh : '0;
    x_add_o       = valid_o ? AW_X'(int'(pix_r) % ARRAY_COLS) : '0;
    y_add_o       = valid_o ? AW_Y'(int'(pix_r) / ARRAY_COLS) : '0;
    grp_req_o     = grp_req;
    grp_release_o = (state == RELEASE);
    active_o      = (|pend) || (state != IDLE);
    state_o       = state;
  end

endmodule
